inertial_reader: RTL and testbench

Front end between the SPI master and the inertial sensor. After reset it waits out the sensor power-up delay and writes the sensor configuration. On each data-ready interrupt it reads the eight rate/acceleration bytes and presents them as four signed 16-bit readings with a one-cycle `vld` strobe. It feeds the incline/roll integrator and drives the SPI master through its `wrt`/`done` command handshake.

---
 rtl/inertial_reader_if.sv | 10 +
 rtl/inertial_reader.sv | 181 ++++++++++++++++++
 tb/tb_inertial_reader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inertial_reader_if.sv
// Command/response handshake between the inertial reader and the SPI master.
interface inertial_reader_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/inertial_reader.sv
// Inertial sensor front end: power-up delay, configuration writes, then an
// eight-byte read on every data-ready interrupt, published as four readings.
module inertial_reader #(
  parameter int unsigned INIT_WAIT = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     INT,
  inertial_reader_if.master        spi,
  output logic                     vld,
  output logic signed [15:0]       roll_rt,
  output logic signed [15:0]       yaw_rt,
  output logic signed [15:0]       AY,
  output logic signed [15:0]       AZ
);

  typedef enum logic [2:0] {
    INIT_DLY,
    CFG,
    IDLE,
    READ,
    UPD
  } state_t;

  localparam logic [15:0] LP_WAIT = 16'(INIT_WAIT);

  state_t             r_state;
  logic [15:0]        r_timer;
  logic [2:0]         r_idx;
  logic               r_busy;
  logic               r_wrt;
  logic [15:0]        r_cmd;
  logic               r_vld;
  logic               r_int_meta;
  logic               r_int_s;
  logic [7:0]         r_stg [8];
  logic signed [15:0] r_roll;
  logic signed [15:0] r_yaw;
  logic signed [15:0] r_ay;
  logic signed [15:0] r_az;

  logic               w_done_ok;
  logic [2:0]         w_next_idx;
  logic               w_unused_rd_hi;

  function automatic logic [15:0] cfg_word(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_word = 16'h0D02;
      2'd1:    cfg_word = 16'h1053;
      2'd2:    cfg_word = 16'h1150;
      default: cfg_word = 16'h1460;
    endcase
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    rd_cmd = 16'hA400;
      3'd1:    rd_cmd = 16'hA500;
      3'd2:    rd_cmd = 16'hA600;
      3'd3:    rd_cmd = 16'hA700;
      3'd4:    rd_cmd = 16'hAA00;
      3'd5:    rd_cmd = 16'hAB00;
      3'd6:    rd_cmd = 16'hAC00;
      default: rd_cmd = 16'hAD00;
    endcase
  endfunction

  assign w_done_ok      = spi.done & r_busy;
  assign w_next_idx     = r_idx + 3'd1;
  assign w_unused_rd_hi = &{1'b0, spi.rd_data[15:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT_DLY;
      r_timer    <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_wrt      <= 1'b0;
      r_cmd      <= '0;
      r_vld      <= 1'b0;
      r_int_meta <= 1'b0;
      r_int_s    <= 1'b0;
      r_roll     <= '0;
      r_yaw      <= '0;
      r_ay       <= '0;
      r_az       <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        r_stg[i] <= '0;
      end
    end else begin
      r_int_meta <= INT;
      r_int_s    <= r_int_meta;
      r_wrt      <= 1'b0;
      r_vld      <= 1'b0;

      case (r_state)
        INIT_DLY: begin
          if (r_timer == LP_WAIT) begin
            r_state <= CFG;
            r_idx   <= '0;
            r_wrt   <= 1'b1;
            r_busy  <= 1'b1;
            r_cmd   <= cfg_word(2'd0);
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        CFG: begin
          if (w_done_ok) begin
            r_busy <= 1'b0;
            if (r_idx == 3'd3) begin
              r_state <= IDLE;
            end else begin
              r_idx  <= w_next_idx;
              r_wrt  <= 1'b1;
              r_busy <= 1'b1;
              r_cmd  <= cfg_word(w_next_idx[1:0]);
            end
          end
        end

        IDLE: begin
          if (r_int_s) begin
            r_state <= READ;
            r_idx   <= '0;
            r_wrt   <= 1'b1;
            r_busy  <= 1'b1;
            r_cmd   <= rd_cmd(3'd0);
          end
        end

        READ: begin
          if (w_done_ok) begin
            r_busy       <= 1'b0;
            r_stg[r_idx] <= spi.rd_data[7:0];
            if (r_idx == 3'd7) begin
              // Publish at the last done so vld lands in the UPD cycle; the
              // final byte bypasses staging.
              r_state <= UPD;
              r_vld   <= 1'b1;
              r_roll  <= {r_stg[1], r_stg[0]};
              r_yaw   <= {r_stg[3], r_stg[2]};
              r_ay    <= {r_stg[5], r_stg[4]};
              r_az    <= {spi.rd_data[7:0], r_stg[6]};
            end else begin
              r_idx  <= w_next_idx;
              r_wrt  <= 1'b1;
              r_busy <= 1'b1;
              r_cmd  <= rd_cmd(w_next_idx);
            end
          end
        end

        UPD: begin
          // A still-high interrupt skips the IDLE cycle and re-reads at once.
          if (r_int_s) begin
            r_state <= READ;
            r_idx   <= '0;
            r_wrt   <= 1'b1;
            r_busy  <= 1'b1;
            r_cmd   <= rd_cmd(3'd0);
          end else begin
            r_state <= IDLE;
          end
        end

        default: r_state <= INIT_DLY;
      endcase
    end
  end

  assign spi.wrt = r_wrt;
  assign spi.cmd = r_cmd;
  assign vld     = r_vld;
  assign roll_rt = r_roll;
  assign yaw_rt  = r_yaw;
  assign AY      = r_ay;
  assign AZ      = r_az;

endmodule

// File: tb/tb_inertial_reader.sv
// Directed bench for inertial_reader with a 5-cycle-latency SPI master model.
module tb_inertial_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic INT = 1'b0;
  logic vld;
  logic signed [15:0] roll_rt, yaw_rt, AY, AZ;

  inertial_reader_if bus();

  inertial_reader #(.INIT_WAIT(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .INT     (INT),
    .spi     (bus),
    .vld     (vld),
    .roll_rt (roll_rt),
    .yaw_rt  (yaw_rt),
    .AY      (AY),
    .AZ      (AZ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  rd_lo;
    logic [15:0] exp_cmd;
  } rdvec_t;

  rdvec_t      tbl [8];
  logic [15:0] cfg_exp [4];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [7:0]  rd_bytes [16];
  int unsigned rd_limit = 1000000;
  int unsigned model_rd = 0;
  int unsigned log_n    = 0;
  int unsigned done_n   = 0;
  int unsigned vld_n    = 0;
  int unsigned cyc      = 0;
  logic [15:0] log_cmd  [256];
  int unsigned log_wcyc [256];
  int unsigned log_dcyc [256];

  // SPI master model: done 5 cycles after each accepted wrt
  initial begin : spi_model
    int unsigned cnt;
    cnt = 0;
    bus.done = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.done = 1'b0;
      if (vld === 1'b1) vld_n++;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.done = 1'b1;
          if (bus.cmd[15]) begin
            bus.rd_data = {8'hEE, rd_bytes[model_rd % 16]};
            model_rd++;
          end else begin
            bus.rd_data = 16'hDEAD;
          end
          log_dcyc[(log_n - 1) % 256] = cyc;
          done_n++;
        end
      end else if (bus.wrt === 1'b1 && rst === 1'b0) begin
        log_cmd[log_n % 256]  = bus.cmd;
        log_wcyc[log_n % 256] = cyc;
        log_n++;
        if (!bus.cmd[15] || model_rd < rd_limit) cnt = 5;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic init_seq(input string tag);
    int unsigned first, lb, db;
    bit seen;
    lb = log_n;
    db = done_n;
    first = 0;
    seen = 1'b0;
    for (int unsigned c = 1; c <= 60 && !seen; c++) begin
      tick();
      if (bus.wrt === 1'b1) begin
        seen = 1'b1;
        first = c;
      end
    end
    chk({tag, "_first_wrt_cyc"}, first, 17);
    chk({tag, "_first_cmd"}, bus.cmd, 16'h0D02);
    for (int unsigned c = 0; c < 200 && done_n < db + 4; c++) tick();
    chk({tag, "_cfg_done_count"}, done_n - db, 4);
    for (int unsigned i = 0; i < 4; i++)
      chk($sformatf("%s_cfg_cmd%0d", tag, i), log_cmd[lb + i], cfg_exp[i]);
    for (int unsigned i = 0; i < 3; i++)
      chk($sformatf("%s_cfg_gap%0d", tag, i), log_wcyc[lb + i + 1] - log_dcyc[lb + i], 1);
  endtask

  task automatic wait_vld(input string nm, input int unsigned lim, output bit ok);
    ok = 1'b0;
    for (int unsigned c = 0; c < lim && !ok; c++) begin
      tick();
      if (vld === 1'b1) ok = 1'b1;
    end
    chk({nm, "_vld_seen"}, ok, 1);
  endtask

  initial begin : main
    int unsigned lb, vb, base, n1;
    bit ok, partial;
    logic w1, w2, w3;

    tbl[0] = '{8'h34, 16'hA400};
    tbl[1] = '{8'h12, 16'hA500};
    tbl[2] = '{8'hCD, 16'hA600};
    tbl[3] = '{8'hAB, 16'hA700};
    tbl[4] = '{8'h00, 16'hAA00};
    tbl[5] = '{8'h80, 16'hAB00};
    tbl[6] = '{8'hFF, 16'hAC00};
    tbl[7] = '{8'h7F, 16'hAD00};
    cfg_exp[0] = 16'h0D02;
    cfg_exp[1] = 16'h1053;
    cfg_exp[2] = 16'h1150;
    cfg_exp[3] = 16'h1460;
    for (int unsigned i = 0; i < 16; i++) rd_bytes[i] = 8'h00;

    // Reset held three cycles
    rst = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_wrt_vld%0d", i), {bus.wrt, vld}, 0);
      chk($sformatf("rst_outs%0d", i), {roll_rt, yaw_rt, AY, AZ}, 0);
    end
    rst = 1'b0;
    init_seq("init");

    lb = log_n;
    repeat (30) tick();
    chk("idle_no_wrt", log_n - lb, 0);

    // Read with table values
    lb = log_n;
    vb = vld_n;
    base = model_rd;
    for (int unsigned i = 0; i < 8; i++) rd_bytes[(base + i) % 16] = tbl[i].rd_lo;
    INT = 1'b1;
    tick(); w1 = bus.wrt;
    tick(); w2 = bus.wrt;
    tick(); w3 = bus.wrt;
    INT = 1'b0;
    chk("int_lat_early", {w1, w2}, 0);
    chk("int_lat_wrt", w3, 1);
    chk("int_lat_cmd", bus.cmd, 16'hA400);
    partial = 1'b0;
    ok = 1'b0;
    for (int unsigned c = 0; c < 200 && !ok; c++) begin
      tick();
      if (vld === 1'b1) ok = 1'b1;
      else if ({roll_rt, yaw_rt, AY, AZ} !== 64'd0) partial = 1'b1;
    end
    chk("rd_vld_seen", ok, 1);
    chk("rd_no_partial", partial, 0);
    chk("rd_roll", {roll_rt}, 16'h1234);
    chk("rd_yaw", {yaw_rt}, 16'hABCD);
    chk("rd_ay", {AY}, 16'h8000);
    chk("rd_az", {AZ}, 16'h7FFF);
    tick();
    chk("rd_vld_pulse", vld, 0);
    for (int unsigned i = 0; i < 8; i++)
      chk($sformatf("rd_cmd%0d", i), log_cmd[lb + i], tbl[i].exp_cmd);
    repeat (20) tick();
    chk("rd_vld_count", vld_n - vb, 1);

    // Eighth done withheld: outputs hold
    lb = log_n;
    vb = vld_n;
    base = model_rd;
    for (int unsigned i = 0; i < 8; i++) rd_bytes[(base + i) % 16] = 8'h55;
    rd_limit = model_rd + 7;
    INT = 1'b1;
    repeat (3) tick();
    INT = 1'b0;
    repeat (100) tick();
    chk("held_roll", {roll_rt}, 16'h1234);
    chk("held_yaw", {yaw_rt}, 16'hABCD);
    chk("held_ay", {AY}, 16'h8000);
    chk("held_az", {AZ}, 16'h7FFF);
    chk("held_no_vld", vld_n - vb, 0);
    chk("held_wrt_count", log_n - lb, 8);
    do_reset(3);
    rd_limit = 1000000;
    chk("held_rst_outs", {roll_rt, yaw_rt, AY, AZ}, 0);
    init_seq("reinit1");

    // INT held high across two read sets
    lb = log_n;
    vb = vld_n;
    base = model_rd;
    for (int unsigned i = 0; i < 8; i++) begin
      rd_bytes[(base + i) % 16] = tbl[i].rd_lo;
      rd_bytes[(base + 8 + i) % 16] = (i % 2 == 0) ? 8'(i / 2 + 1) : 8'h00;
    end
    INT = 1'b1;
    wait_vld("hold1", 200, ok);
    chk("hold1_roll", {roll_rt}, 16'h1234);
    chk("hold1_az", {AZ}, 16'h7FFF);
    n1 = log_n;
    tick();
    chk("hold_restart_wrt", bus.wrt, 1);
    chk("hold_restart_cmd", bus.cmd, 16'hA400);
    repeat (4) tick();
    INT = 1'b0;
    wait_vld("hold2", 200, ok);
    chk("hold2_roll", {roll_rt}, 16'h0001);
    chk("hold2_yaw", {yaw_rt}, 16'h0002);
    chk("hold2_ay", {AY}, 16'h0003);
    chk("hold2_az", {AZ}, 16'h0004);
    chk("hold_reads_between", log_n - n1, 8);
    repeat (30) tick();
    chk("hold_vld_count", vld_n - vb, 2);
    chk("hold_wrt_count", log_n - lb, 16);

    // Reset during the fifth read
    lb = log_n;
    vb = vld_n;
    base = model_rd;
    for (int unsigned i = 0; i < 16; i++) rd_bytes[i] = 8'h11;
    INT = 1'b1;
    repeat (3) tick();
    INT = 1'b0;
    ok = 1'b0;
    for (int unsigned c = 0; c < 200 && !ok; c++) begin
      tick();
      if (log_n >= lb + 5) ok = 1'b1;
    end
    chk("mr_fifth_read", ok, 1);
    chk("mr_fifth_cmd", log_cmd[(lb + 4) % 256], 16'hAA00);
    tick();
    rst = 1'b1;
    tick();
    chk("mr_wrt_vld_low", {bus.wrt, vld}, 0);
    repeat (5) tick();
    rst = 1'b0;
    chk("mr_rst_outs", {roll_rt, yaw_rt, AY, AZ}, 0);
    init_seq("reinit2");
    chk("mr_no_vld", vld_n - vb, 0);
    chk("mr_outs_zero", {roll_rt, yaw_rt, AY, AZ}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
